multicycle_ctrl: RTL and testbench

- Control FSM for the multi-cycle RV32I datapath: regfile, ALU, immediate generator, PC/IR registers and a shared instruction/data memory port.
- Sequences fetch, decode, execute, memory and writeback.
- Drives immediate-format select, ALU operand muxes and register write enables.
- Arbitrates the single memory port between instruction fetch and load/store.

---
 rtl/riscv_pkg.sv | 73 +++++++
 rtl/branch_cond.sv | 22 ++
 rtl/multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcode constants, datapath mux encodings
// and the multi-cycle controller state set.
package riscv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'd0,
        SRCA_PC   = 2'd1,
        SRCA_ZERO = 2'd2
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2
    } src_b_e;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } ctrl_state_e;

    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

    function automatic imm_sel_e imm_sel_of(input logic [6:0] op);
        case (op)
            STORE:      return IMM_S;
            BRANCH:     return IMM_B;
            LUI, AUIPC: return IMM_U;
            JAL:        return IMM_J;
            default:    return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch outcome from the ALU flags; funct3 010/011 have no branch meaning.
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    output logic       taken,
    output logic       bad_funct3
);

    always_comb begin
        taken      = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3)
            3'b000:         taken = alu_zero;
            3'b001:         taken = !alu_zero;
            3'b100, 3'b110: taken = alu_lt;
            3'b101, 3'b111: taken = !alu_lt;
            default:        bad_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with shared instruction/data memory port.
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
//
// state  | meaning
// FETCH  | request instruction at PC; on mem_ready load IR and PC+4
// DECODE | IR valid, opcode legality check
// EXEC   | ALU operation, branch resolve, jump PC update
// MEM    | load/store data access at ALU result
// WB     | single-cycle register file write
// TRAP   | illegal opcode/funct3 or memory timeout; held until reset
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  wb_sel,
    output logic        reg_we,
    output logic [31:0] pc_init,
    output logic        illegal,
    output logic [31:0] retired
);

    localparam int unsigned      TMR_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MEM_TIMEOUT - 1);

    ctrl_state_e      state;
    ctrl_state_e      state_nxt;
    logic [TMR_W-1:0] tmr;

    logic    is_load;
    logic    is_store;
    logic    is_branch;
    logic    is_jal;
    logic    is_jalr;
    logic    br_taken;
    logic    br_bad;
    logic    mem_wait;
    logic    timeout_hit;
    logic    fetch_done;
    logic    mem_done;
    src_a_e  src_a_d;
    src_b_e  src_b_d;
    pc_sel_e pc_sel_d;
    wb_sel_e wb_sel_d;

    assign pc_init   = RESET_PC;
    assign is_load   = (opcode == LOAD);
    assign is_store  = (opcode == STORE);
    assign is_branch = (opcode == BRANCH);
    assign is_jal    = (opcode == JAL);
    assign is_jalr   = (opcode == JALR);

    branch_cond u_branch_cond (
        .funct3     (funct3),
        .alu_zero   (alu_zero),
        .alu_lt     (alu_lt),
        .taken      (br_taken),
        .bad_funct3 (br_bad)
    );

    // mem_req is a flop that is low in reset, so these strobes cannot fire while n_rst is held.
    assign mem_wait    = mem_req && !mem_ready;
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && (tmr == '0);
    assign fetch_done  = (state == FETCH) && mem_req && mem_ready;
    assign mem_done    = (state == MEM) && mem_req && mem_ready;

    assign ir_we = fetch_done;
    assign pc_we = fetch_done
                || ((state == EXEC) && (is_jal || is_jalr || (is_branch && br_taken && !br_bad)));

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (fetch_done)       state_nxt = DECODE;
                else if (timeout_hit) state_nxt = TRAP;
            end
            DECODE: state_nxt = op_legal(opcode) ? EXEC : TRAP;
            EXEC: begin
                if (is_branch)                state_nxt = br_bad ? TRAP : FETCH;
                else if (is_load || is_store) state_nxt = MEM;
                else                          state_nxt = WB;
            end
            MEM: begin
                if (mem_done)         state_nxt = is_store ? FETCH : WB;
                else if (timeout_hit) state_nxt = TRAP;
            end
            WB:      state_nxt = FETCH;
            TRAP:    state_nxt = TRAP;
            default: state_nxt = TRAP;
        endcase
    end

    // AUIPC and branch targets take the PC of this instruction; the datapath keeps
    // the pre-increment PC in its own register because PC already moved in FETCH.
    always_comb begin
        src_a_d  = SRCA_RS1;
        src_b_d  = SRCB_RS2;
        pc_sel_d = PC_PLUS4;
        wb_sel_d = WB_ALU;
        case (opcode)
            OP_IMM: src_b_d = SRCB_IMM;
            LUI: begin
                src_a_d = SRCA_ZERO;
                src_b_d = SRCB_IMM;
            end
            AUIPC: begin
                src_a_d = SRCA_PC;
                src_b_d = SRCB_IMM;
            end
            LOAD: begin
                src_b_d  = SRCB_IMM;
                wb_sel_d = WB_MEM;
            end
            STORE:  src_b_d  = SRCB_IMM;
            BRANCH: pc_sel_d = PC_IMM;
            JAL: begin
                pc_sel_d = PC_IMM;
                wb_sel_d = WB_PC4;
            end
            JALR: begin
                src_b_d  = SRCB_IMM;
                pc_sel_d = PC_ALU;
                wb_sel_d = WB_PC4;
            end
            default: ;
        endcase
    end

    // Outputs are decoded from the next state so they are valid from the first cycle of a state.
    // IR only becomes valid in DECODE, so operand/immediate selects start at EXEC and hold through WB.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= FETCH;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr_sel <= 1'b0;
            pc_sel       <= PC_PLUS4;
            imm_sel      <= IMM_I;
            alu_src_a    <= SRCA_RS1;
            alu_src_b    <= SRCB_RS2;
            wb_sel       <= WB_ALU;
            reg_we       <= 1'b0;
            illegal      <= 1'b0;
            tmr          <= TMR_LOAD;
        end else begin
            state        <= state_nxt;
            mem_req      <= (state_nxt == FETCH) || (state_nxt == MEM);
            mem_we       <= (state_nxt == MEM) && is_store;
            mem_addr_sel <= (state_nxt == MEM);
            reg_we       <= (state_nxt == WB);
            illegal      <= (state_nxt == TRAP);
            pc_sel       <= (state_nxt == EXEC) ? pc_sel_d : PC_PLUS4;
            wb_sel       <= (state_nxt == WB) ? wb_sel_d : WB_ALU;
            if (state_nxt inside {EXEC, MEM, WB}) begin
                imm_sel   <= imm_sel_of(opcode);
                alu_src_a <= src_a_d;
                alu_src_b <= src_b_d;
            end else begin
                imm_sel   <= IMM_I;
                alu_src_a <= SRCA_RS1;
                alu_src_b <= SRCB_RS2;
            end
            if ((state_nxt != state) || !mem_wait) begin
                tmr <= TMR_LOAD;
            end else if (tmr != '0) begin
                tmr <= tmr - TMR_W'(1);
            end
        end
    end

`ifdef PERF_CNT_EN
    logic retire;

    assign retire = (state_nxt == FETCH) && (state inside {EXEC, MEM, WB});

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + 32'd1;
        end
    end
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed cases plus random instruction
// streams checked phase by phase against an instruction-level model.
module tb_multicycle_ctrl;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

    localparam logic [6:0] O_OP    = 7'h33;
    localparam logic [6:0] O_IMM   = 7'h13;
    localparam logic [6:0] O_LD    = 7'h03;
    localparam logic [6:0] O_ST    = 7'h23;
    localparam logic [6:0] O_BR    = 7'h63;
    localparam logic [6:0] O_JAL   = 7'h6F;
    localparam logic [6:0] O_JALR  = 7'h67;
    localparam logic [6:0] O_LUI   = 7'h37;
    localparam logic [6:0] O_AUIPC = 7'h17;

`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        n_rst     = 1'b1;
    logic [6:0]  opcode    = '0;
    logic [2:0]  funct3    = '0;
    logic        alu_zero  = 1'b0;
    logic        alu_lt    = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [2:0]  imm_sel;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  wb_sel;
    logic        reg_we;
    logic [31:0] pc_init;
    logic        illegal;
    logic [31:0] retired;

    int          n_chk   = 0;
    int          n_err   = 0;
    logic [31:0] exp_ret = '0;
    int          br_z    = -1;

    multicycle_ctrl #(
        .RESET_PC    (TB_RESET_PC),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .opcode       (opcode),
        .funct3       (funct3),
        .alu_zero     (alu_zero),
        .alu_lt       (alu_lt),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .imm_sel      (imm_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .wb_sel       (wb_sel),
        .reg_we       (reg_we),
        .pc_init      (pc_init),
        .illegal      (illegal),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, illegal}
    function automatic logic [31:0] ctl();
        return {25'd0, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, illegal};
    endfunction

    function automatic logic [31:0] cv(input logic req, input logic we, input logic asel,
                                       input logic irwe, input logic pcwe, input logic regwe,
                                       input logic ill);
        return {25'd0, req, we, asel, irwe, pcwe, regwe, ill};
    endfunction

    function automatic bit op_ok(input logic [6:0] op);
        return op inside {O_OP, O_IMM, O_LD, O_ST, O_BR, O_JAL, O_JALR, O_LUI, O_AUIPC};
    endfunction

    function automatic logic [31:0] want_imm(input logic [6:0] op);
        case (op)
            O_ST:           return 32'd1;
            O_BR:           return 32'd2;
            O_LUI, O_AUIPC: return 32'd3;
            O_JAL:          return 32'd4;
            default:        return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] want_src_a(input logic [6:0] op);
        case (op)
            O_LUI:   return 32'd2;
            O_AUIPC: return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] want_src_b(input logic [6:0] op);
        return (op == O_OP) ? 32'd0 : 32'd1;
    endfunction

    task automatic count_retire();
        if (PERF) exp_ret = exp_ret + 32'd1;
    endtask

    task automatic trap_hold();
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'($urandom);
            alu_zero  = 1'($urandom);
            #2;
            chk("trap", ctl(), cv(0, 0, 0, 0, 0, 0, 1));
            step();
        end
    endtask

    task automatic do_reset();
        n_rst     = 1'b0;
        mem_ready = 1'b1;
        alu_zero  = 1'b1;
        alu_lt    = 1'b1;
        #2;
        chk("rst_ctl", ctl(), 32'd0);
        chk("rst_sel", 32'({pc_sel, imm_sel, alu_src_a, alu_src_b, wb_sel}), 32'd0);
        chk("rst_retired", retired, 32'd0);
        step();
        step();
        n_rst = 1'b1;
        #2;
        chk("post_rst_ctl", ctl(), 32'd0);
        chk("post_rst_retired", retired, 32'd0);
        step();
        exp_ret = '0;
    endtask

    // One instruction from its first FETCH cycle; needs_rst means the DUT is now in TRAP.
    task automatic run_instr(input logic [31:0] instr, input int fwait, input int mwait,
                             input bit rst_in_mem, output bit needs_rst);
        logic [6:0] op;
        logic [2:0] f3;
        logic       rdy, br, bad, tkn, pcwe, is_ld, is_st;
        op        = instr[6:0];
        f3        = instr[14:12];
        needs_rst = 1'b0;
        for (int w = 0; w <= fwait; w++) begin
            rdy       = (w == fwait);
            mem_ready = rdy;
            alu_zero  = 1'($urandom);
            alu_lt    = 1'($urandom);
            #2;
            if (w == 0) chk("retired", retired, exp_ret);
            chk("fetch", ctl(), cv(1, 0, 0, rdy, rdy, 0, 0));
            if (rdy) chk("fetch_pc_sel", 32'(pc_sel), 32'd0);
            step();
        end
        opcode    = op;
        funct3    = f3;
        mem_ready = 1'($urandom);
        #2;
        chk("decode", ctl(), 32'd0);
        step();
        if (!op_ok(op)) begin
            trap_hold();
            needs_rst = 1'b1;
            return;
        end
        br        = (op == O_BR);
        is_ld     = (op == O_LD);
        is_st     = (op == O_ST);
        alu_zero  = (br_z >= 0) ? br_z[0] : 1'($urandom);
        alu_lt    = 1'($urandom);
        mem_ready = 1'($urandom);
        bad       = br && (f3 == 3'd2 || f3 == 3'd3);
        case (f3)
            3'd0:       tkn = alu_zero;
            3'd1:       tkn = !alu_zero;
            3'd4, 3'd6: tkn = alu_lt;
            3'd5, 3'd7: tkn = !alu_lt;
            default:    tkn = 1'b0;
        endcase
        pcwe = (op == O_JAL) || (op == O_JALR) || (br && tkn && !bad);
        #2;
        chk("exec", ctl(), cv(0, 0, 0, 0, pcwe, 0, 0));
        chk("exec_imm_sel", 32'(imm_sel), want_imm(op));
        if (pcwe) chk("exec_pc_sel", 32'(pc_sel), (op == O_JALR) ? 32'd2 : 32'd1);
        if (!br && op != O_JAL) begin
            chk("exec_src_a", 32'(alu_src_a), want_src_a(op));
            chk("exec_src_b", 32'(alu_src_b), want_src_b(op));
        end
        step();
        if (bad) begin
            trap_hold();
            needs_rst = 1'b1;
            return;
        end
        if (br) begin
            count_retire();
            return;
        end
        if (is_ld || is_st) begin
            for (int w = 0; w <= mwait; w++) begin
                mem_ready = (w == mwait) && !rst_in_mem;
                #2;
                chk("mem", ctl(), cv(1, is_st, 1, 0, 0, 0, 0));
                if (rst_in_mem) begin
                    n_rst = 1'b0;
                    #1;
                    chk("rst_mem_req", 32'(mem_req), 32'd0);
                    do_reset();
                    return;
                end
                step();
            end
            if (is_st) begin
                count_retire();
                return;
            end
        end
        mem_ready = 1'($urandom);
        #2;
        chk("wb", ctl(), cv(0, 0, 0, 0, 0, 1, 0));
        chk("wb_sel", 32'(wb_sel), is_ld ? 32'd1 : ((op == O_JAL || op == O_JALR) ? 32'd2 : 32'd0));
        step();
        count_retire();
    endtask

    initial begin
        bit tr;
        do_reset();
        chk("pc_init", pc_init, TB_RESET_PC);

        run_instr(32'h0050_0093, 0, 0, 1'b0, tr);   // addi x1,x0,5
        run_instr(32'h0010_2023, 0, 3, 1'b0, tr);   // sw x1,0(x0), 3 wait cycles
        br_z = 1;
        run_instr(32'h0000_0463, 0, 0, 1'b0, tr);   // beq taken
        br_z = 0;
        run_instr(32'h0000_0463, 0, 0, 1'b0, tr);   // beq not taken
        br_z = -1;
        run_instr(32'h0050_0093, 15, 0, 1'b0, tr);  // ready on the last allowed wait cycle
        run_instr(32'h0000_2083, 1, 2, 1'b0, tr);   // lw
        run_instr(32'hFFFF_FFFF, 0, 0, 1'b0, tr);
        chk("illegal_trap", 32'(tr), 32'd1);
        do_reset();

        for (int c = 0; c < 16; c++) begin
            mem_ready = 1'b0;
            #2;
            chk("timeout_wait", ctl(), cv(1, 0, 0, 0, 0, 0, 0));
            step();
        end
        #2;
        chk("timeout_trap", ctl(), cv(0, 0, 0, 0, 0, 0, 1));
        step();
        do_reset();

        run_instr(32'h0050_0093, 0, 0, 1'b0, tr);
        run_instr(32'h0010_2023, 0, 2, 1'b1, tr);   // reset while MEM is waiting
        run_instr(32'h0050_0093, 0, 0, 1'b0, tr);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] ins;
            logic [6:0]  op;
            bit          t;
            case ($urandom_range(0, 10))
                0:       op = O_OP;
                1:       op = O_IMM;
                2:       op = O_LD;
                3:       op = O_ST;
                4, 9:    op = O_BR;
                5:       op = O_JAL;
                6:       op = O_JALR;
                7:       op = O_LUI;
                8:       op = O_AUIPC;
                default: begin
                    op = 7'($urandom);
                    if (op_ok(op)) op = 7'h7F;
                end
            endcase
            ins      = $urandom;
            ins[6:0] = op;
            run_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, t);
            if (t) do_reset();
        end

        #2;
        chk("final_retired", retired, exp_ret);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
